// File: rtl/muldiv_pkg.sv
// Shared encodings and op-decoding helpers for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // MUL keeps only the low half, which is identical for signed and unsigned operands.
  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_operand_cond.sv
// Two-lane conditional negator: magnitude plus sign flag for signed inputs, or a forced
// negation via the flip inputs when applying the final sign correction.
module muldiv_operand_cond #(
  parameter int unsigned Width = 32
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             a_signed_i,
  input  logic             b_signed_i,
  input  logic             a_flip_i,
  input  logic             b_flip_i,
  output logic [Width-1:0] a_mag_o,
  output logic [Width-1:0] b_mag_o,
  output logic             a_neg_o,
  output logic             b_neg_o
);

  always_comb begin
    a_neg_o = a_signed_i & a_i[Width-1];
    b_neg_o = b_signed_i & b_i[Width-1];
    a_mag_o = (a_neg_o ^ a_flip_i) ? ((~a_i) + Width'(1)) : a_i;
    b_mag_o = (b_neg_o ^ b_flip_i) ? ((~b_i) + Width'(1)) : b_i;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV32M multiply/divide unit, one bit per cycle on operand magnitudes.
// Optional MULDIV_EARLY_OUT_EN: zero divisor/multiplier and signed overflow bypass CALC.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [4:0]      rd_out,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            sign_a_q, sign_a_d;
  logic            sign_b_q, sign_b_d;
  // hi/lo: product halves for multiply, remainder/quotient for divide.
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic            done_q, done_d;
  logic [4:0]      rd_out_q, rd_out_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN-1:0] abs_a, abs_b;
  logic            sgn_a, sgn_b;

  muldiv_operand_cond #(
    .Width (XLEN)
  ) u_cond_in (
    .a_i        (a),
    .b_i        (b),
    .a_signed_i (is_signed_a(op)),
    .b_signed_i (is_signed_b(op)),
    .a_flip_i   (1'b0),
    .b_flip_i   (1'b0),
    .a_mag_o    (abs_a),
    .b_mag_o    (abs_b),
    .a_neg_o    (sgn_a),
    .b_neg_o    (sgn_b)
  );

  logic [XLEN:0]   mul_sum;
  logic [XLEN-1:0] mul_hi_nxt, mul_lo_nxt;
  logic [XLEN:0]   div_shift, div_diff;
  logic            div_ge;
  logic [XLEN-1:0] div_hi_nxt, div_lo_nxt;

  always_comb begin
    mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_nxt = mul_sum[XLEN:1];
    mul_lo_nxt = {mul_sum[0], lo_q[XLEN-1:1]};
    // Restoring division: the borrow bit tells whether the divisor fits.
    div_shift  = {hi_q, lo_q[XLEN-1]};
    div_diff   = div_shift - {1'b0, opnd_q};
    div_ge     = ~div_diff[XLEN];
    div_hi_nxt = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_lo_nxt = {lo_q[XLEN-2:0], div_ge};
  end

  logic [2*XLEN-1:0] fix_a_in, fix_b_in, fix_a_out, fix_b_out;
  logic              fix_neg_a, fix_neg_b;

  always_comb begin
    fix_a_in = is_div(op_q) ? {{XLEN{1'b0}}, lo_q} : {hi_q, lo_q};
    fix_b_in = {{XLEN{1'b0}}, hi_q};
  end

  muldiv_operand_cond #(
    .Width (2 * XLEN)
  ) u_cond_fix (
    .a_i        (fix_a_in),
    .b_i        (fix_b_in),
    .a_signed_i (1'b0),
    .b_signed_i (1'b0),
    .a_flip_i   (sign_a_q ^ sign_b_q),
    .b_flip_i   (sign_a_q),
    .a_mag_o    (fix_a_out),
    .b_mag_o    (fix_b_out),
    .a_neg_o    (fix_neg_a),
    .b_neg_o    (fix_neg_b)
  );

  logic unused_fix;
  assign unused_fix = ^{fix_b_out[2*XLEN-1:XLEN], fix_neg_a, fix_neg_b};

  logic            div_zero;
  logic [XLEN-1:0] fix_result;

  always_comb begin
    div_zero   = (opnd_q == '0);
    fix_result = fix_b_out[XLEN-1:0];
    case (op_q)
      OP_MUL:                       fix_result = fix_a_out[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_result = fix_a_out[2*XLEN-1:XLEN];
      // A zero divisor yields all ones regardless of the dividend sign.
      OP_DIV, OP_DIVU:              fix_result = div_zero ? '1 : fix_a_out[XLEN-1:0];
      default:                      fix_result = fix_b_out[XLEN-1:0];
    endcase
  end

`ifdef MULDIV_EARLY_OUT_EN
  logic b_zero, div_ovf, early_out;
  always_comb begin
    b_zero    = (b == '0);
    div_ovf   = is_div(op) && is_signed_b(op) && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    early_out = b_zero | div_ovf;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    rd_d     = rd_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    done_d   = 1'b0;
    rd_out_d = rd_out_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d  = S_CALC;
          cnt_d    = '0;
          op_d     = op;
          rd_d     = rd_in;
          sign_a_d = sgn_a;
          sign_b_d = sgn_b;
          hi_d     = '0;
          lo_d     = is_div(op) ? abs_a : abs_b;
          opnd_d   = is_div(op) ? abs_b : abs_a;
`ifdef MULDIV_EARLY_OUT_EN
          // Preload hi/lo so FIX produces the architected special-case values.
          if (early_out) begin
            state_d = S_FIX;
            hi_d    = (is_div(op) && b_zero) ? abs_a : '0;
            lo_d    = (is_div(op) && !b_zero) ? abs_a : '0;
          end
`endif
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          hi_d  = is_div(op_q) ? div_hi_nxt : mul_hi_nxt;
          lo_d  = is_div(op_q) ? div_lo_nxt : mul_lo_nxt;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(XLEN - 1)) begin
            state_d = S_FIX;
          end
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          result_d = fix_result;
          rd_out_d = rd_q;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      done_q   <= 1'b0;
      rd_out_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      done_q   <= done_d;
      rd_out_q <= rd_out_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign rd_out = rd_out_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, random ops against an
// arithmetic reference model, and flush / reset / back-to-back sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] MIN_NEG = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [4:0]  rd_out;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(
    .XLEN (XLEN)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd_in  (rd_in),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .rd_out (rd_out),
    .result (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x,
                                            input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'h0, x});
    uy = longint'({32'h0, y});
    case (o)
      OP_MUL:    begin p = 64'(sx * sy); return p[31:0];  end
      OP_MULH:   begin p = 64'(sx * sy); return p[63:32]; end
      OP_MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
      OP_MULHU:  begin p = 64'(ux * uy); return p[63:32]; end
      OP_DIV: begin
        if (y == 32'h0) return 32'hFFFF_FFFF;
        if (x == MIN_NEG && y == 32'hFFFF_FFFF) return x;
        return 32'(sx / sy);
      end
      OP_DIVU:   return (y == 32'h0) ? 32'hFFFF_FFFF : x / y;
      OP_REM: begin
        if (y == 32'h0) return x;
        if (x == MIN_NEG && y == 32'hFFFF_FFFF) return 32'h0;
        return 32'(sx % sy);
      end
      default:   return (y == 32'h0) ? x : x % y;
    endcase
  endfunction

  // Cycles from the start cycle up to and including the done cycle.
  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x,
                                     input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
    if (y == 32'h0) return 2;
    if ((o == OP_DIV || o == OP_REM) && x == MIN_NEG && y == 32'hFFFF_FFFF) return 2;
`endif
    return XLEN + 2;
  endfunction

  // Called at the negedge just after the accept edge; bounded wait for done.
  task automatic wait_done(output int lat);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = n + 1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input logic [31:0] exp_res, input int exp_lat,
                        input string name);
    int lat;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; rd_in = r;
    @(negedge clk);
    start = 1'b0;
    chk({name, " busy"}, {31'b0, busy}, 32'd1);
    wait_done(lat);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " result"}, result, exp_res);
    chk({name, " rd_out"}, {27'b0, rd_out}, {27'b0, r});
    @(negedge clk);
    chk({name, " done pulse"}, {31'b0, done}, 32'd0);
    chk({name, " result hold"}, result, exp_res);
  endtask

  initial begin
    int          seen, lat;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    logic [4:0]  rr;
    int unsigned sel;

    vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[3]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD};
    vecs[4]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF};
    vecs[5]  = '{OP_DIVU,   32'd5,        32'd0,        32'hFFFF_FFFF};
    vecs[6]  = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[8]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFFF};
    vecs[9]  = '{OP_REM,    32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9};
    vecs[10] = '{OP_REMU,   32'd7,        32'd0,        32'd7};
    vecs[11] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF};
    vecs[12] = '{OP_MUL,    32'h1234_5678, 32'd0,        32'd0};
    vecs[13] = '{OP_DIVU,   32'd100,      32'd7,        32'd14};
    vecs[14] = '{OP_REMU,   32'd100,      32'd7,        32'd2};
    vecs[15] = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[16] = '{OP_DIV,    32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD};
    vecs[17] = '{OP_REM,    32'd7,        32'hFFFF_FFFE, 32'd1};
    vecs[18] = '{OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; a = '0; b = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", {27'b0, rd_out}, 32'd0);
    rst = 1'b0;

    // start together with flush in IDLE is dropped
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_DIVU; a = 32'd50; b = 32'd5; rd_in = 5'd1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("start+flush busy", {31'b0, busy}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("start+flush no done", seen, 0);

    for (int i = 0; i < 19; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 5'(i + 1), vecs[i].exp,
             exp_latency(vecs[i].op, vecs[i].a, vecs[i].b), $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 7);
      ro  = 3'($urandom_range(0, 7));
      ra  = (sel == 2) ? MIN_NEG : $urandom;
      rb  = (sel == 0) ? 32'h0 : (sel == 1 || sel == 2) ? 32'hFFFF_FFFF : $urandom;
      rr  = 5'($urandom);
      run_op(ro, ra, rb, rr, ref_model(ro, ra, rb), exp_latency(ro, ra, rb),
             $sformatf("rand%0d op%0d a=%h b=%h", i, ro, ra, rb));
    end

    // flush mid-operation, then restart one cycle later
    @(negedge clk);
    start = 1'b1; op = OP_DIV; a = 32'd1000; b = 32'd7; rd_in = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("flush pre busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'b0, busy}, 32'd0);
    chk("flush done", {31'b0, done}, 32'd0);
    run_op(OP_DIV, 32'd1000, 32'd7, 5'd4, 32'd142, XLEN + 2, "after flush");

    // reset mid-MULHSU discards the op
    @(negedge clk);
    start = 1'b1; op = OP_MULHSU; a = 32'hFFFF_FFFB; b = 32'd3; rd_in = 5'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst busy", {31'b0, busy}, 32'd0);
    chk("mid rst done", {31'b0, done}, 32'd0);
    chk("mid rst result", result, 32'd0);
    chk("mid rst rd_out", {27'b0, rd_out}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("mid rst no done", seen, 0);

    // start held high while busy is ignored; taken again on the done cycle
    @(negedge clk);
    start = 1'b1; op = OP_MUL; a = 32'd123; b = 32'd456; rd_in = 5'd10;
    @(negedge clk);
    op = OP_DIVU; a = 32'd1000; b = 32'd10; rd_in = 5'd11;
    chk("held busy", {31'b0, busy}, 32'd1);
    wait_done(lat);
    chk("held latency", lat, XLEN + 2);
    chk("held result", result, 32'd56088);
    chk("held rd_out", {27'b0, rd_out}, 32'd10);
    @(negedge clk);
    start = 1'b0;
    chk("b2b busy", {31'b0, busy}, 32'd1);
    wait_done(lat);
    chk("b2b latency", lat, XLEN + 2);
    chk("b2b result", result, 32'd100);
    chk("b2b rd_out", {27'b0, rd_out}, 32'd11);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
